// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control and scoreboard for the ARM64 pipelined CPU.
// Tracks valid/rd/reg_write/mem_read for every pipeline register and derives
// PC and stage enables, ID/EX bubbles, load-use stalls and memory freezes.
// Register 0 is IF/ID (only its valid bit is tracked here, since its fields
// arrive on the dec_* inputs), register 1 is ID/EX, the last one is MEM/WB.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int LOAD_LAT   = 1,
  parameter int REG_W      = 5,
  parameter int ZERO_REG   = 31,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [REG_W-1:0]      dec_rs1,
  input  logic [REG_W-1:0]      dec_rs2,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic [REG_W-1:0]      dec_rd,
  input  logic                  dec_reg_write,
  input  logic                  dec_mem_read,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  bubble,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  genvar gi;

  logic [NUM_STAGES-1:0] valid_reg;
  logic [REG_W-1:0]      rd_reg [1:NUM_STAGES-1];
  logic                  rw_reg [1:NUM_STAGES-1];
  logic                  mr_reg [1:NUM_STAGES-1];
  logic [CNT_W-1:0]      count_reg;
  logic [LOAD_LAT:1]     hit;
  logic                  hz;

  assign stage_valid = valid_reg;
  assign stall_count = count_reg;

  // A load still inside the not-yet-forwardable window whose rd is read by decode.
  generate
    for (gi = 1; gi <= LOAD_LAT; gi++) begin : g_hit
      assign hit[gi] = valid_reg[gi] & rw_reg[gi] & mr_reg[gi] &
                       (rd_reg[gi] != REG_W'(ZERO_REG)) &
                       ((dec_use_rs1 & (dec_rs1 == rd_reg[gi])) |
                        (dec_use_rs2 & (dec_rs2 == rd_reg[gi])));
    end
  endgenerate

  assign hz = valid_reg[0] & (|hit);

  // Control outputs: freeze beats redirect beats load-use stall beats normal flow.
  always_comb begin
    pc_en    = 1'b1;
    stage_en = '1;
    bubble   = 1'b0;
    stall    = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        pc_en                  = 1'b0;
        stage_en               = '0;
        stage_en[NUM_STAGES-1] = 1'b1;
      end else if (branch_taken) begin
        bubble = 1'b1;
      end else if (hz) begin
        stall       = 1'b1;
        pc_en       = 1'b0;
        stage_en[0] = 1'b0;
        bubble      = 1'b1;
      end
    end
  end

  // IF/ID valid and ID/EX capture (or kill/bubble) from the decode inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg[0] <= 1'b0;
      valid_reg[1] <= 1'b0;
      rd_reg[1]    <= '0;
      rw_reg[1]    <= 1'b0;
      mr_reg[1]    <= 1'b0;
    end else if (!mem_busy) begin
      rd_reg[1] <= dec_rd;
      if (branch_taken) begin
        valid_reg[0] <= 1'b0;
        valid_reg[1] <= 1'b0;
        rw_reg[1]    <= 1'b0;
        mr_reg[1]    <= 1'b0;
      end else if (hz) begin
        valid_reg[1] <= 1'b0;
        rw_reg[1]    <= 1'b0;
        mr_reg[1]    <= 1'b0;
      end else begin
        valid_reg[0] <= fetch_valid;
        valid_reg[1] <= valid_reg[0];
        rw_reg[1]    <= dec_reg_write;
        mr_reg[1]    <= dec_mem_read;
      end
    end
  end

  // Later registers shift; during a freeze only the last one moves, taking a bubble.
  generate
    for (gi = 2; gi < NUM_STAGES; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
          rd_reg[gi]    <= '0;
          rw_reg[gi]    <= 1'b0;
          mr_reg[gi]    <= 1'b0;
        end else if (mem_busy) begin
          if (gi == NUM_STAGES - 1) begin
            valid_reg[gi] <= 1'b0;
            rw_reg[gi]    <= 1'b0;
            mr_reg[gi]    <= 1'b0;
          end
        end else begin
          valid_reg[gi] <= valid_reg[gi-1];
          rd_reg[gi]    <= rd_reg[gi-1];
          rw_reg[gi]    <= rw_reg[gi-1];
          mr_reg[gi]    <= mr_reg[gi-1];
        end
      end
    end
  endgenerate

  // Saturating count of lost cycles (load-use stalls plus memory freezes).
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if ((stall || mem_busy) && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default geometry, and a deeper
// pipe with LOAD_LAT=2 and a narrow counter) share one random stimulus stream
// and are each compared every cycle against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_valid = 1'b1;
  logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic       dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0;
  logic       dec_reg_write = 1'b0, dec_mem_read = 1'b0;
  logic       branch_taken = 1'b0, mem_busy = 1'b0;

  logic        a_pc_en, a_bubble, a_stall;
  logic [3:0]  a_stage_en, a_stage_valid;
  logic [15:0] a_count;
  logic        b_pc_en, b_bubble, b_stall;
  logic [4:0]  b_stage_en, b_stage_valid;
  logic [2:0]  b_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut_a (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_en(a_pc_en), .stage_en(a_stage_en), .stage_valid(a_stage_valid),
    .bubble(a_bubble), .stall(a_stall), .stall_count(a_count)
  );

  pipe_hazard_ctrl #(.NUM_STAGES(5), .LOAD_LAT(2), .CNT_W(3)) u_dut_b (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_en(b_pc_en), .stage_en(b_stage_en), .stage_valid(b_stage_valid),
    .bubble(b_bubble), .stall(b_stall), .stall_count(b_count)
  );

  // One in-flight instruction as seen by the scoreboard.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } ent_t;

  ent_t pipe [2][8];
  int   cnt  [2];
  int   ns   [2] = '{4, 5};
  int   ll   [2] = '{1, 2};
  int   cw   [2] = '{16, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Compare one instance against the model, then advance the model by one edge.
  task automatic step_model(input int c);
    int          n = ns[c];
    int          l = ll[c];
    bit          hz = 1'b0;
    logic [31:0] all_en, e_en, e_sv;
    logic [31:0] g_pc, g_en, g_sv, g_bub, g_stall, g_cnt;
    bit          e_pc, e_bub, e_stall;
    string       who = (c == 0) ? "a" : "b";
    ent_t        nop = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};

    if (c == 0) begin
      g_pc = 32'(a_pc_en); g_en = 32'(a_stage_en); g_sv = 32'(a_stage_valid);
      g_bub = 32'(a_bubble); g_stall = 32'(a_stall); g_cnt = 32'(a_count);
    end else begin
      g_pc = 32'(b_pc_en); g_en = 32'(b_stage_en); g_sv = 32'(b_stage_valid);
      g_bub = 32'(b_bubble); g_stall = 32'(b_stall); g_cnt = 32'(b_count);
    end

    for (int k = 1; k <= l; k++) begin
      if (pipe[c][k].v && pipe[c][k].rw && pipe[c][k].mr && pipe[c][k].rd != 5'd31 &&
          ((dec_use_rs1 && dec_rs1 == pipe[c][k].rd) || (dec_use_rs2 && dec_rs2 == pipe[c][k].rd)))
        hz = 1'b1;
    end
    hz = hz && pipe[c][0].v;

    all_en = (32'd1 << n) - 32'd1;
    e_pc = 1'b1; e_en = all_en; e_bub = 1'b0; e_stall = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        e_pc = 1'b0; e_en = 32'd1 << (n - 1);
      end else if (branch_taken) begin
        e_bub = 1'b1;
      end else if (hz) begin
        e_pc = 1'b0; e_en = all_en & ~32'd1; e_bub = 1'b1; e_stall = 1'b1;
      end
    end
    e_sv = '0;
    for (int k = 0; k < n; k++) e_sv[k] = pipe[c][k].v;

    chk($sformatf("cyc%0d %s pc_en", cyc, who), g_pc, 32'(e_pc));
    chk($sformatf("cyc%0d %s stage_en", cyc, who), g_en, e_en);
    chk($sformatf("cyc%0d %s stage_valid", cyc, who), g_sv, e_sv);
    chk($sformatf("cyc%0d %s bubble", cyc, who), g_bub, 32'(e_bub));
    chk($sformatf("cyc%0d %s stall", cyc, who), g_stall, 32'(e_stall));
    chk($sformatf("cyc%0d %s stall_count", cyc, who), g_cnt, 32'(cnt[c]));

    if (reset) begin
      for (int k = 0; k < 8; k++) pipe[c][k] = nop;
      cnt[c] = 0;
    end else begin
      if ((e_stall || mem_busy) && cnt[c] < (1 << cw[c]) - 1) cnt[c]++;
      if (mem_busy) begin
        pipe[c][n-1] = nop;
      end else begin
        for (int k = n - 1; k >= 2; k--) pipe[c][k] = pipe[c][k-1];
        if (branch_taken) begin
          pipe[c][1] = nop;
          pipe[c][0].v = 1'b0;
        end else if (hz) begin
          pipe[c][1] = nop;
        end else begin
          pipe[c][1] = '{v: pipe[c][0].v, rd: dec_rd, rw: dec_reg_write, mr: dec_mem_read};
          pipe[c][0].v = fetch_valid;
        end
      end
    end
  endtask

  // Apply one cycle of inputs away from the active edge and check both instances.
  task automatic drive(input bit r, input bit fv, input bit [4:0] rs1, input bit u1,
                       input bit [4:0] rs2, input bit u2, input bit [4:0] rd,
                       input bit rw, input bit mr, input bit br, input bit mb);
    @(negedge clk);
    reset = r; fetch_valid = fv;
    dec_rs1 = rs1; dec_use_rs1 = u1; dec_rs2 = rs2; dec_use_rs2 = u2;
    dec_rd = rd; dec_reg_write = rw; dec_mem_read = mr;
    branch_taken = br; mem_busy = mb;
    #1;
    step_model(0);
    step_model(1);
    cyc++;
  endtask

  function automatic bit [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  initial begin
    int busy_left = 0;
    for (int c = 0; c < 2; c++) begin
      cnt[c] = 0;
      for (int k = 0; k < 8; k++) pipe[c][k] = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
    end

    // reset with fetch active, then a load of X2 followed by dependent ADDs
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    drive(0, 1, 2, 1, 4, 1, 6, 1, 0, 0, 0);
    drive(0, 1, 2, 1, 4, 1, 6, 1, 0, 0, 0);
    drive(0, 1, 2, 1, 4, 1, 6, 1, 0, 0, 0);
    // load to XZR with a reader, then a load with no reader
    drive(0, 1, 0, 0, 0, 0, 31, 1, 1, 0, 0);
    drive(0, 1, 31, 1, 31, 1, 7, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    drive(0, 1, 2, 0, 2, 0, 8, 1, 0, 0, 0);
    // load, then freeze with redirect and a dependent decode, then redirect on release
    drive(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 3, 1, 0, 0, 9, 1, 0, 1, 1);
    drive(0, 1, 3, 1, 0, 0, 9, 1, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);

    // randomized traffic over a small register set so dependencies are frequent
    for (int i = 0; i < 4000; i++) begin
      bit mb;
      if (busy_left > 0) begin
        mb = 1'b1;
        busy_left--;
      end else begin
        mb = 1'b0;
        if ($urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 4);
      end
      drive(($urandom_range(0, 249) == 0), ($urandom_range(0, 7) != 0),
            pick_reg(), 1'($urandom), pick_reg(), 1'($urandom), pick_reg(),
            ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 11) == 0), mb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control and scoreboard block for the ARM64 pipelined CPU.
- Replaces the fixed load-use hazard check and the scattered enable/flush wiring around the IF/ID … MEM/WB registers.
- Tracks valid, destination and load status per pipeline register. Generates PC/stage enables, bubbles and flushes for any depth and load latency.
- Adds multi-cycle memory stall (freeze) support and a stall performance counter.

Parameters:
- NUM_STAGES, 4, number of pipeline registers; index 0 = IF/ID, 1 = ID/EX, last = MEM/WB; legal range ≥ 4.
- LOAD_LAT, 1, cycles after EX before load data is forwardable; load-use is checked against registers 1..LOAD_LAT; legal range 1..NUM_STAGES-2.
- REG_W, 5, register address width.
- ZERO_REG, 31, register index that is never a hazard (XZR).
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- fetch_valid  input  1  IF presents a valid instruction.
- dec_rs1  input  REG_W  decode source 1.
- dec_rs2  input  REG_W  decode source 2.
- dec_use_rs1  input  1  decode reads rs1.
- dec_use_rs2  input  1  decode reads rs2.
- dec_rd  input  REG_W  decode destination.
- dec_reg_write  input  1  decode instruction writes rd.
- dec_mem_read  input  1  decode instruction is a load.
- branch_taken  input  1  redirect; kill IF/ID and ID/EX contents.
- mem_busy  input  1  memory stage not complete this cycle.
- pc_en  output  1  PC register enable.
- stage_en  output  NUM_STAGES  per-register load enable.
- stage_valid  output  NUM_STAGES  registered valid bit per register.
- bubble  output  1  ID/EX loads a NOP this cycle.
- stall  output  1  load-use stall this cycle.
- stall_count  output  CNT_W  saturating count of stall or mem_busy cycles.

Behaviour:
- Reset is synchronous and active-high. On the clock edge with reset=1: stage_valid=0, all tracked rd/reg_write/mem_read cleared, stall_count=0.
- While reset=1, combinational outputs are pc_en=1, stage_en=all 1, bubble=0, stall=0.
- Reset mid-operation discards all in-flight state in one cycle.
- Per register k the block holds: valid_k, rd_k, rw_k, mr_k. Register 1 captures the dec_* inputs. Register k+1 captures register k's fields.
- Hazard: hz = stage_valid[0] & ∃k∈[1,LOAD_LAT] with valid_k & rw_k & mr_k & rd_k≠ZERO_REG & ((dec_use_rs1 & dec_rs1==rd_k) | (dec_use_rs2 & dec_rs2==rd_k)). Purely combinational.
- Priority is mem_busy > branch_taken > hz > normal, evaluated each cycle:
  - mem_busy=1 (freeze):
    - pc_en=0, stage_en[0..NUM_STAGES-2]=0; all fields of those registers hold.
    - Last register loads valid=0, rw=0 (bubble into WB).
    - branch_taken and hz are ignored; the source stays frozen and re-asserts.
    - stall=0, bubble=0.
  - branch_taken=1:
    - pc_en=1, all stage_en=1.
    - Next cycle valid_0=0 and valid_1=0, with rw_1=0 and mr_1=0; later registers shift normally.
    - stall=0, bubble=1.
  - hz=1:
    - stall=1, pc_en=0, stage_en[0]=0 (IF/ID holds).
    - Register 1 loads valid=0, rw=0, mr=0; bubble=1.
    - Registers ≥2 shift.
  - normal:
    - All enables=1; valid_0 ← fetch_valid; register 1 ← {stage_valid[0], dec_*}; others shift.
- Invalid entries never cause a hazard.
- A load in register k stalls the dependent instruction until it reaches register LOAD_LAT+1.
  - Back-to-back dependency costs LOAD_LAT stall cycles.
  - One independent instruction between them costs LOAD_LAT-1 cycles.
- stall_count increments by 1 on each non-reset edge where stall=1 or mem_busy=1. It saturates at 2^CNT_W-1 and does not wrap.
- Latency: all control outputs are combinational from inputs and current state. State updates on the next edge only.

Test Plan:
- Reset: hold reset 2 cycles with fetch_valid=1 -> stage_valid=4'b0000, stall_count=0, pc_en=1. One cycle after release -> stage_valid=4'b0001.
- Load-use (defaults): LDUR X2 in ID/EX, decode ADD reads X2 -> stall=1, pc_en=0, stage_en=4'b1110, bubble=1 for 1 cycle. Next cycle stage_valid[1]=0, stall=0, stall_count=1.
- ZERO_REG / no-use: load to X31 with dependent decode, or load X2 with dec_use_rs1=dec_use_rs2=0 -> stall=0 throughout.
- LOAD_LAT=2, NUM_STAGES=5: back-to-back dependent load -> 2 stall cycles. One independent instruction between them -> 1 stall cycle.
- mem_busy held 3 cycles with branch_taken=1 and hz=1 during -> pc_en=0, stage_en=4'b1000, stage_valid[3]=0 each cycle, stage_valid[2:0] unchanged. On release with branch_taken=1 -> stage_valid[1:0]=0 next cycle. stall_count +3 (+1 if hz remains after).
- Saturation, CNT_W=2: 5 consecutive stall cycles -> stall_count goes 1, 2, 3, 3, 3.
